// File: rtl/crossbar_ingress_port_if.sv
// Handshake bundle between an upstream source, crossbar_ingress_port and
// one input slice of crossbar_switch.
interface crossbar_ingress_port_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DEST_W-1:0] in_dest;
    logic [DATA_W-1:0] in_data;
    logic              sw_req;
    logic [DEST_W-1:0] sw_dest;
    logic [DATA_W-1:0] sw_data;
    logic              sw_grant;

    modport master (
        output in_valid,
        output in_dest,
        output in_data,
        output sw_grant,
        input  in_ready,
        input  sw_req,
        input  sw_dest,
        input  sw_data
    );

    modport slave (
        input  in_valid,
        input  in_dest,
        input  in_data,
        input  sw_grant,
        output in_ready,
        output sw_req,
        output sw_dest,
        output sw_data
    );
endinterface

// File: rtl/crossbar_ingress_port.sv
// crossbar_ingress_port: FIFO-buffered requester for one crossbar input.
// Define CROSSBAR_INGRESS_STATS_EN to add grant_cnt/stall_cnt counters.
module crossbar_ingress_port #(
    parameter int DATA_W   = 32,
    parameter int DEST_W   = 2,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    crossbar_ingress_port_if.slave bus,
    output logic                   starve,
    output logic [$clog2(DEPTH):0] level
`ifdef CROSSBAR_INGRESS_STATS_EN
    ,
    output logic [15:0]            grant_cnt,
    output logic [15:0]            stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [7:0]    WAIT_MAX = 8'(MAX_WAIT);
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_LVL  = PW'(1);

    typedef enum logic [1:0] {
        EMPTY,
        PENDING,
        STARVED
    } state_t;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    state_t        state;
    state_t        state_nxt;
    logic [7:0]    wait_cnt;
    logic [7:0]    wait_nxt;
    logic [7:0]    wait_inc;
    logic          push;
    logic          pop;

    assign count        = wr_ptr - rd_ptr;
    assign level        = count;
    assign bus.in_ready = (count != FULL_LVL);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.sw_req && bus.sw_grant;

    assign head         = mem[rd_ptr[AW-1:0]];
    assign bus.sw_dest  = head.dest;
    assign bus.sw_data  = head.data;
    assign bus.sw_req   = (state != EMPTY);
    assign starve       = (state == STARVED);

    // Storage is cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= entry_t'{dest: bus.in_dest,
                                            data: bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_LVL;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_LVL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    assign wait_inc = (wait_cnt < WAIT_MAX) ? wait_cnt + 8'd1 : wait_cnt;

    // Request stays up while any entry remains, so back-to-back grants
    // retire one word per cycle without a bubble.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        unique case (state)
            EMPTY: begin
                wait_nxt = '0;
                if (push) begin
                    state_nxt = PENDING;
                end
            end
            PENDING, STARVED: begin
                if (pop) begin
                    wait_nxt  = '0;
                    state_nxt = (count == ONE_LVL && !push) ? EMPTY : PENDING;
                end else begin
                    wait_nxt = wait_inc;
                    if (wait_inc >= WAIT_MAX) begin
                        state_nxt = STARVED;
                    end
                end
            end
            default: begin
                state_nxt = EMPTY;
                wait_nxt  = '0;
            end
        endcase
    end

`ifdef CROSSBAR_INGRESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && grant_cnt != 16'hFFFF) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
            if (bus.sw_req && !bus.sw_grant && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crossbar_ingress_port.sv
// Self-checking bench for crossbar_ingress_port: vector table, corner-case
// sequences and randomized traffic against a queue-based reference.
module tb_crossbar_ingress_port;
    localparam int DATA_W   = 32;
    localparam int DEST_W   = 2;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        starve;
    logic [2:0]  level;
`ifdef CROSSBAR_INGRESS_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    crossbar_ingress_port_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) bus ();

    crossbar_ingress_port #(
        .DATA_W  (DATA_W),
        .DEST_W  (DEST_W),
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .starve   (starve),
        .level    (level)
`ifdef CROSSBAR_INGRESS_STATS_EN
        ,
        .grant_cnt(grant_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [33:0] mq[$];
    int m_wait = 0;
    int m_grants = 0;
    int m_stalls = 0;

    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic [31:0] x;
        logic        g;
        logic        e_req;
        logic [2:0]  e_lvl;
        logic        e_rdy;
        logic        chk_hd;
        logic [1:0]  e_dest;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: a plain queue plus a saturating wait count.
    task automatic model_step(input logic v, input logic g,
                              input logic [1:0] d, input logic [31:0] x);
        bit req;
        bit rdy;
        req = (mq.size() != 0);
        rdy = (mq.size() != DEPTH);
        if (req && g) begin
            void'(mq.pop_front());
            m_wait = 0;
            if (m_grants < 65535) m_grants++;
        end else if (req) begin
            if (m_wait < MAX_WAIT) m_wait++;
            if (m_stalls < 65535) m_stalls++;
        end
        if (v && rdy) mq.push_back({d, x});
    endtask

    task automatic model_reset();
        mq.delete();
        m_wait = 0;
        m_grants = 0;
        m_stalls = 0;
    endtask

    task automatic tick(input logic v, input logic [1:0] d,
                        input logic [31:0] x, input logic g);
        bus.in_valid = v;
        bus.in_dest  = d;
        bus.in_data  = x;
        bus.sw_grant = g;
        model_step(v, g, d, x);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit nonempty;
        nonempty = (mq.size() != 0);
        chk({tag, ".req"}, 32'(bus.sw_req), 32'(nonempty));
        chk({tag, ".ready"}, 32'(bus.in_ready), 32'(mq.size() != DEPTH));
        chk({tag, ".level"}, 32'(level), 32'(mq.size()));
        chk({tag, ".starve"}, 32'(starve),
            32'(nonempty && m_wait >= MAX_WAIT));
        if (nonempty) begin
            chk({tag, ".dest"}, 32'(bus.sw_dest), 32'(mq[0][33:32]));
            chk({tag, ".data"}, bus.sw_data, mq[0][31:0]);
        end
`ifdef CROSSBAR_INGRESS_STATS_EN
        chk({tag, ".grant_cnt"}, 32'(grant_cnt), 32'(m_grants));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stalls));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".req"}, 32'(bus.sw_req), 32'd0);
        chk({tag, ".ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, ".level"}, 32'(level), 32'd0);
        chk({tag, ".starve"}, 32'(starve), 32'd0);
        chk({tag, ".dest"}, 32'(bus.sw_dest), 32'd0);
        chk({tag, ".data"}, bus.sw_data, 32'd0);
`ifdef CROSSBAR_INGRESS_STATS_EN
        chk({tag, ".grant_cnt"}, 32'(grant_cnt), 32'd0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    function automatic vec_t mk(logic v, logic [1:0] d, logic [31:0] x,
                                logic g, logic rq, logic [2:0] lv,
                                logic rd, logic ch, logic [1:0] ed,
                                logic [31:0] eda);
        vec_t r;
        r.v = v; r.d = d; r.x = x; r.g = g;
        r.e_req = rq; r.e_lvl = lv; r.e_rdy = rd;
        r.chk_hd = ch; r.e_dest = ed; r.e_data = eda;
        return r;
    endfunction

    initial begin
        int gp;
        bus.in_valid = 1'b0;
        bus.in_dest  = '0;
        bus.in_data  = '0;
        bus.sw_grant = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vt[0]  = mk(1'b1, 2'd2, 32'hA1A1A1A1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 2'd2, 32'hA1A1A1A1);
        vt[1]  = mk(1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 32'h0);
        vt[2]  = mk(1'b1, 2'd0, 32'h11111111, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 2'd0, 32'h11111111);
        vt[3]  = mk(1'b1, 2'd1, 32'h22222222, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 2'd0, 32'h11111111);
        vt[4]  = mk(1'b1, 2'd3, 32'h33333333, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 2'd0, 32'h11111111);
        vt[5]  = mk(1'b1, 2'd2, 32'h44444444, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 2'd0, 32'h11111111);
        vt[6]  = mk(1'b1, 2'd1, 32'h55555555, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 2'd0, 32'h11111111);
        vt[7]  = mk(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 2'd1, 32'h22222222);
        vt[8]  = mk(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 2'd3, 32'h33333333);
        vt[9]  = mk(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 2'd2, 32'h44444444);
        vt[10] = mk(1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 32'h0);
        vt[11] = mk(1'b1, 2'd1, 32'hAAAA0001, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 2'd1, 32'hAAAA0001);
        vt[12] = mk(1'b1, 2'd2, 32'hAAAA0002, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 2'd1, 32'hAAAA0001);
        vt[13] = mk(1'b1, 2'd3, 32'hDEADBEEF, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 2'd2, 32'hAAAA0002);
        vt[14] = mk(1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 2'd3, 32'hDEADBEEF);
        vt[15] = mk(1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            tick(vt[i].v, vt[i].d, vt[i].x, vt[i].g);
            chk($sformatf("vec%0d.req", i), 32'(bus.sw_req), 32'(vt[i].e_req));
            chk($sformatf("vec%0d.level", i), 32'(level), 32'(vt[i].e_lvl));
            chk($sformatf("vec%0d.ready", i), 32'(bus.in_ready), 32'(vt[i].e_rdy));
            if (vt[i].chk_hd) begin
                chk($sformatf("vec%0d.dest", i), 32'(bus.sw_dest), 32'(vt[i].e_dest));
                chk($sformatf("vec%0d.data", i), bus.sw_data, vt[i].e_data);
            end
        end

        // Starvation: one entry left ungranted for 20 cycles.
        tick(1'b1, 2'd1, 32'hC0FFEE00, 1'b0);
        chk("starve.req", 32'(bus.sw_req), 32'd1);
        for (int n = 1; n <= 20; n++) begin
            tick(1'b0, 2'd0, 32'h0, 1'b0);
            chk($sformatf("starve.cyc%0d", n), 32'(starve),
                32'(n >= MAX_WAIT));
        end
        tick(1'b0, 2'd0, 32'h0, 1'b1);
        chk("starve.release", 32'(starve), 32'd0);
        chk("starve.level", 32'(level), 32'd0);
        chk("starve.req_off", 32'(bus.sw_req), 32'd0);
        check_model("starve.model");

        // Reset while three words are waiting and the head is starved.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 2'(i), 32'hBB000000 + 32'(i), 1'b0);
        end
        repeat (16) tick(1'b0, 2'd0, 32'h0, 1'b0);
        chk("midrst.pre_level", 32'(level), 32'd3);
        chk("midrst.pre_starve", 32'(starve), 32'd1);
        check_model("midrst.pre");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with varying grant pressure.
        gp = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: gp = 3;
                    1: gp = 45;
                    default: gp = 90;
                endcase
            end
            tick(1'($urandom_range(0, 99) < 60), 2'($urandom),
                 32'($urandom), 1'($urandom_range(0, 99) < gp));
            check_model($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crossbar_ingress_port.md
# crossbar_ingress_port

Requester-side adapter for one input of `crossbar_switch`: buffers upstream words with their destination in a small FIFO and drives the switch's per-input `req`/`dest`/`data_in` slice. It holds each request stable until the switch grants it, then retires it. A wait counter flags starvation when an output is contended. One instance sits on each of the N switch inputs, between the source and the crossbar.

## Interface
- DATA_W, 32, payload width; matches one `data_in` slice of the switch
- DEST_W, 2, destination index width; log2(M)
- DEPTH, 4, FIFO entries; power of two, ≥2
- MAX_WAIT, 15, ungranted request cycles before `starve` asserts; 1..255
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  FIFO can accept; equals (count != DEPTH)
- in_dest  in  DEST_W  destination output for the word
- in_data  in  DATA_W  payload
- sw_req  out  1  to switch `req[i]`
- sw_dest  out  DEST_W  to switch `dest[i]`
- sw_data  out  DATA_W  to switch `data_in[i]`
- sw_grant  in  1  from switch `grant[i]`
- starve  out  1  head request waited ≥MAX_WAIT cycles
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO: storage DEPTH×(DEST_W+DATA_W); wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits, so the MSB distinguishes full from empty; both wrap naturally.
- Push when in_valid && in_ready. Pop (transfer) when sw_req && sw_grant on a rising edge.
- sw_dest/sw_data always show the FIFO head. They are stable while sw_req=1 until the pop edge.
- Full: in_ready=0. There is no same-cycle pass-through, even if a pop occurs that cycle.
- Simultaneous push and pop when not full and not empty: level is unchanged, and both pointers advance.
- sw_grant while sw_req=0 is ignored: no pop, no counter change.
- FSM states:
  - EMPTY: sw_req=0. Goes to PENDING when level becomes nonzero.
  - PENDING: sw_req=1, wait_cnt increments on each ungranted cycle. On a grant, goes to EMPTY if that was the last entry, otherwise stays in PENDING with wait_cnt=0. Goes to STARVED when wait_cnt reaches MAX_WAIT.
  - STARVED: sw_req=1, starve=1. On a grant, exits to EMPTY or PENDING as above and clears wait_cnt and starve.
- wait_cnt is 8-bit and saturates at MAX_WAIT.

## Timing
- Reset (async assert, sync-safe deassert): pointers=0, level=0, FSM=EMPTY, sw_req=0, sw_dest=0, sw_data=0, starve=0, wait_cnt=0.
- in_ready reads 1 during reset and after reset while not full.
- Push-to-request latency: a word pushed into an empty FIFO at edge k gives sw_req=1 after edge k.
- Grant at edge k retires the head. The next entry, if any, appears after edge k with sw_req still 1, so there is no bubble.
- Pop throughput: one word per cycle while sw_grant stays high.
- starve rises after the MAX_WAIT-th consecutive ungranted cycle. It falls after the granting edge.
- Reset mid-transfer: outputs drop immediately to their reset values and FIFO contents are discarded.

## Configuration
- CROSSBAR_INGRESS_STATS_EN defined: adds `grant_cnt` (out, 16) and `stall_cnt` (out, 16).
  - grant_cnt increments on each pop.
  - stall_cnt increments on each cycle with sw_req=1 && sw_grant=0.
  - Both saturate at 16'hFFFF and reset to 0.
- CROSSBAR_INGRESS_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset, push {dest=2, data=32'hA1A1A1A1}, sw_grant=1 held -> sw_req=1 one cycle after the push, with sw_dest=2 and sw_data=A1A1A1A1. After the grant edge: sw_req=0, level=0.
- Push 4 words with sw_grant=0 -> level=4, in_ready=0. A 5th push is refused, and sw_data stays at the first word.
- Full FIFO, sw_grant=1 for 4 cycles -> words pop in order, one per cycle, with no bubble. sw_req=0 afterwards.
- sw_grant=0 for 20 cycles with one entry, MAX_WAIT=15 -> starve=1 after 15 cycles. Then sw_grant=1 -> starve=0 and level=0 on the next cycle.
- Push 32'hDEADBEEF and grant the head in the same cycle at level=2 -> level stays 2 and the FIFO order is preserved.
- Assert rst_n=0 mid-stream at level=3 -> sw_req, starve, level=0 immediately. With the macro defined, grant_cnt and stall_cnt are also 0.
